instr_mem_loader: RTL and testbench

//  Boot-time writer for the byte-organised instruction memory: accepts 32-bit program words on a

---
 rtl/riscv_mem_pkg.sv | 16 +
 rtl/instr_mem_loader.sv | 123 ++++++++++++
 tb/tb_instr_mem_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the instruction-memory boot loader and the memory's byte write port.
package riscv_mem_pkg;

   // Byte-addressed instruction memory: 2**MEM_ADDR_BITS bytes
   localparam int MEM_ADDR_BITS  = 12;
   localparam int BYTES_PER_WORD = 4;

   // Loader sequencing states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

endpackage

// File: rtl/instr_mem_loader.sv
// Boot-time loader: takes 32-bit program words from a valid/ready stream and writes them
// little-endian into the byte-wide instruction memory, one byte per cycle. Keeps the CPU
// held in reset until a load has completed.
module instr_mem_loader #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 8,
   parameter int IN_WIDTH      = 32,
   parameter int MEM_ADDR_BITS = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_addr,
   input  logic [MEM_ADDR_BITS-2:0] word_count,
   input  logic                     in_valid,
   input  logic [IN_WIDTH-1:0]      in_data,
   output logic                     in_ready,
   output logic                     we,
   output logic [MEM_ADDR_BITS-1:0] waddr,
   output logic [DATA_WIDTH-1:0]    wdata,
   output logic                     busy,
   output logic                     done,
   output logic                     cpu_hold
);

   import riscv_mem_pkg::*;

   localparam int                     BYTE_IDX_W = $clog2(BYTES_PER_WORD);
   localparam logic [MEM_ADDR_BITS-1:0] WORD_STEP = MEM_ADDR_BITS'(32'(BYTES_PER_WORD));
   localparam logic [MEM_ADDR_BITS-2:0] ONE_WORD  = (MEM_ADDR_BITS-1)'(32'd1);
   localparam logic [BYTE_IDX_W-1:0]    LAST_BYTE = BYTE_IDX_W'(32'(BYTES_PER_WORD - 1));

   loader_state_t            state_q, state_d;
   logic [MEM_ADDR_BITS-1:0] ptr_q, ptr_d;
   logic [MEM_ADDR_BITS-2:0] words_left_q, words_left_d;
   logic [BYTE_IDX_W-1:0]    byte_idx_q, byte_idx_d;
   logic [IN_WIDTH-1:0]      word_reg_q, word_reg_d;
   logic                     cpu_hold_q, cpu_hold_d;

   // Only the in-memory, word-aligned part of base_addr is meaningful
   logic unused_s;
   assign unused_s = ^{base_addr[ADDRESS_WIDTH-1:MEM_ADDR_BITS], base_addr[1:0]};

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= {MEM_ADDR_BITS{1'b0}};
         words_left_q <= {(MEM_ADDR_BITS-1){1'b0}};
         byte_idx_q   <= {BYTE_IDX_W{1'b0}};
         word_reg_q   <= {IN_WIDTH{1'b0}};
         cpu_hold_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         words_left_q <= words_left_d;
         byte_idx_q   <= byte_idx_d;
         word_reg_q   <= word_reg_d;
         cpu_hold_q   <= cpu_hold_d;
      end
   end

   // Next-state logic: sequence accept -> four byte writes -> next word or finish
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      words_left_d = words_left_q;
      byte_idx_d   = byte_idx_q;
      word_reg_d   = word_reg_q;
      cpu_hold_d   = cpu_hold_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               ptr_d        = {base_addr[MEM_ADDR_BITS-1:2], 2'b00};
               words_left_d = word_count;
               byte_idx_d   = {BYTE_IDX_W{1'b0}};
               cpu_hold_d   = 1'b1;
               state_d      = (word_count == {(MEM_ADDR_BITS-1){1'b0}}) ? DONE : LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (in_valid) begin
               word_reg_d = in_data;
               byte_idx_d = {BYTE_IDX_W{1'b0}};
               state_d    = WRITE;
            end else begin
               state_d = LOAD;
            end
         end
         WRITE: begin
            if (byte_idx_q == LAST_BYTE) begin
               byte_idx_d   = {BYTE_IDX_W{1'b0}};
               ptr_d        = ptr_q + WORD_STEP;  // wraps at the top of memory
               words_left_d = words_left_q - ONE_WORD;
               state_d      = (words_left_q == ONE_WORD) ? DONE : LOAD;
            end else begin
               byte_idx_d = byte_idx_q + BYTE_IDX_W'(32'd1);
               state_d    = WRITE;
            end
         end
         DONE: begin
            cpu_hold_d = 1'b0;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode registered state only; write bus is driven to zero outside WRITE
   assign in_ready = (state_q == LOAD);
   assign we       = (state_q == WRITE);
   assign busy     = (state_q == LOAD) || (state_q == WRITE);
   assign done     = (state_q == DONE);
   assign cpu_hold = cpu_hold_q;
   assign waddr    = we ? (ptr_q + MEM_ADDR_BITS'(byte_idx_q)) : {MEM_ADDR_BITS{1'b0}};
   assign wdata    = we ? word_reg_q[32'(byte_idx_q) * DATA_WIDTH +: DATA_WIDTH]
                        : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed testbench for instr_mem_loader: a byte-memory model captures every write and
// each scenario task checks outputs and the memory image against hand-computed values.
module tb_instr_mem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] base_addr;
   logic [10:0] word_count;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        we;
   logic [11:0] waddr;
   logic [7:0]  wdata;
   logic        busy;
   logic        done;
   logic        cpu_hold;

   int n_cmp = 0;
   int n_mis = 0;

   logic [7:0]  mem [0:4095];
   logic [11:0] log_addr [$];
   logic [7:0]  log_data [$];
   int          we_cnt   = 0;
   int          done_cnt = 0;
   int          viol_cnt = 0;

   always #5 clk = ~clk;

   instr_mem_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .busy       (busy),
      .done       (done),
      .cpu_hold   (cpu_hold)
   );

   // Memory model and event counters sampled on the active edge
   always @(posedge clk) begin
      if (we === 1'b1) begin
         mem[waddr] <= wdata;
         log_addr.push_back(waddr);
         log_data.push_back(wdata);
         we_cnt <= we_cnt + 1;
      end
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (in_ready === 1'b1 && we === 1'b1) viol_cnt <= viol_cnt + 1;
   end

   task automatic start_load(input logic [31:0] base, input logic [10:0] cnt);
      start = 1'b1; base_addr = base; word_count = cnt;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      int n = 0;
      in_valid = 1'b1; in_data = w;
      while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_mis++; $display("FAIL send_word_timeout: in_ready=%b required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0; in_data = 32'h0;
   endtask

   task automatic wait_done(input int budget, output int waited);
      waited = 0;
      while (done !== 1'b1 && waited < budget) begin @(negedge clk); waited++; end
      n_cmp++;
      if (done !== 1'b1) begin
         n_mis++; $display("FAIL done_timeout: done=%b required 1 within %0d cycles", done, budget);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n_cmp += 7;
      if (in_ready !== 1'b0) begin n_mis++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      if (we !== 1'b0)       begin n_mis++; $display("FAIL rst_we: got %b want 0", we); end
      if (waddr !== 12'h000) begin n_mis++; $display("FAIL rst_waddr: got %h want 000", waddr); end
      if (wdata !== 8'h00)   begin n_mis++; $display("FAIL rst_wdata: got %h want 00", wdata); end
      if (busy !== 1'b0)     begin n_mis++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (done !== 1'b0)     begin n_mis++; $display("FAIL rst_done: got %b want 0", done); end
      if (cpu_hold !== 1'b1) begin n_mis++; $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); end
   endtask

   task automatic test_reset_mid_load();
      int d0;
      start_load(32'h0000_0300, 11'd1);
      send_word(32'hCAFE_F00D);        // now in first WRITE cycle
      d0 = done_cnt;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n_cmp += 5;
      if (we !== 1'b0)       begin n_mis++; $display("FAIL midrst_we: got %b want 0", we); end
      if (in_ready !== 1'b0) begin n_mis++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
      if (busy !== 1'b0)     begin n_mis++; $display("FAIL midrst_busy: got %b want 0", busy); end
      if (cpu_hold !== 1'b1) begin n_mis++; $display("FAIL midrst_cpu_hold: got %b want 1", cpu_hold); end
      if (done !== 1'b0)     begin n_mis++; $display("FAIL midrst_done: got %b want 0", done); end
      @(negedge clk);
      n_cmp += 4;
      if (done_cnt !== d0)    begin n_mis++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - d0); end
      if (mem[12'h300] !== 8'h0D) begin n_mis++; $display("FAIL midrst_byte0: got %h want 0d", mem[12'h300]); end
      if (mem[12'h301] !== 8'h00) begin n_mis++; $display("FAIL midrst_byte1: got %h want 00", mem[12'h301]); end
      if (we !== 1'b0)       begin n_mis++; $display("FAIL midrst_idle_we: got %b want 0", we); end
   endtask

   task automatic test_single_word();
      int w; int d0 = done_cnt;
      log_addr.delete(); log_data.delete();
      start_load(32'h0000_0000, 11'd1);
      n_cmp += 3;
      if (in_ready !== 1'b1) begin n_mis++; $display("FAIL sw_ready_latency: got %b want 1", in_ready); end
      if (busy !== 1'b1)     begin n_mis++; $display("FAIL sw_busy: got %b want 1", busy); end
      if (cpu_hold !== 1'b1) begin n_mis++; $display("FAIL sw_hold: got %b want 1", cpu_hold); end
      send_word(32'hDEAD_BEEF);
      n_cmp += 4;
      if (we !== 1'b1)       begin n_mis++; $display("FAIL sw_we: got %b want 1", we); end
      if (waddr !== 12'h000) begin n_mis++; $display("FAIL sw_waddr0: got %h want 000", waddr); end
      if (wdata !== 8'hEF)   begin n_mis++; $display("FAIL sw_wdata0: got %h want ef", wdata); end
      if (in_ready !== 1'b0) begin n_mis++; $display("FAIL sw_ready_in_write: got %b want 0", in_ready); end
      wait_done(20, w);
      n_cmp += 2;
      if (w !== 4) begin n_mis++; $display("FAIL sw_done_latency: got %0d want 4", w); end
      if (log_addr.size() !== 4) begin n_mis++; $display("FAIL sw_nwrites: got %0d want 4", log_addr.size()); end
      else begin
         n_cmp += 2;
         if ({log_addr[0], log_addr[1], log_addr[2], log_addr[3]} !== {12'h000, 12'h001, 12'h002, 12'h003}) begin
            n_mis++; $display("FAIL sw_addr_seq: got %h %h %h %h want 000 001 002 003",
                              log_addr[0], log_addr[1], log_addr[2], log_addr[3]);
         end
         if ({log_data[0], log_data[1], log_data[2], log_data[3]} !== 32'hEFBE_ADDE) begin
            n_mis++; $display("FAIL sw_data_seq: got %h %h %h %h want ef be ad de",
                              log_data[0], log_data[1], log_data[2], log_data[3]);
         end
      end
      @(negedge clk);
      n_cmp += 4;
      if (done !== 1'b0)       begin n_mis++; $display("FAIL sw_done_width: got %b want 0", done); end
      if (done_cnt - d0 !== 1) begin n_mis++; $display("FAIL sw_done_count: got %0d want 1", done_cnt - d0); end
      if (cpu_hold !== 1'b0)   begin n_mis++; $display("FAIL sw_release: got %b want 0", cpu_hold); end
      if (busy !== 1'b0)       begin n_mis++; $display("FAIL sw_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_misaligned();
      int w;
      start_load(32'h0000_0103, 11'd2);
      send_word(32'h1122_3344);
      send_word(32'h5566_7788);
      wait_done(20, w);
      n_cmp += 3;
      if ({mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]} !== 32'h1122_3344) begin
         n_mis++; $display("FAIL mis_word0: got %h%h%h%h want 11223344",
                           mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]);
      end
      if ({mem[12'h107], mem[12'h106], mem[12'h105], mem[12'h104]} !== 32'h5566_7788) begin
         n_mis++; $display("FAIL mis_word1: got %h%h%h%h want 55667788",
                           mem[12'h107], mem[12'h106], mem[12'h105], mem[12'h104]);
      end
      if (mem[12'h108] !== 8'h00) begin n_mis++; $display("FAIL mis_overrun: got %h want 00", mem[12'h108]); end
      @(negedge clk);
   endtask

   task automatic test_wrap();
      int w; int we0 = we_cnt;
      log_addr.delete(); log_data.delete();
      start_load(32'h0000_0FFC, 11'd2);
      send_word(32'hA1B2_C3D4);
      send_word(32'h0F1E_2D3C);
      wait_done(20, w);
      n_cmp += 3;
      if (we_cnt - we0 !== 8) begin n_mis++; $display("FAIL wrap_nwrites: got %0d want 8", we_cnt - we0); end
      if ({mem[12'hFFF], mem[12'hFFE], mem[12'hFFD], mem[12'hFFC]} !== 32'hA1B2_C3D4) begin
         n_mis++; $display("FAIL wrap_word0: got %h%h%h%h want a1b2c3d4",
                           mem[12'hFFF], mem[12'hFFE], mem[12'hFFD], mem[12'hFFC]);
      end
      if ({mem[12'h003], mem[12'h002], mem[12'h001], mem[12'h000]} !== 32'h0F1E_2D3C) begin
         n_mis++; $display("FAIL wrap_word1: got %h%h%h%h want 0f1e2d3c",
                           mem[12'h003], mem[12'h002], mem[12'h001], mem[12'h000]);
      end
      if (log_addr.size() == 8) begin
         n_cmp++;
         if ({log_addr[3], log_addr[4]} !== {12'hFFF, 12'h000}) begin
            n_mis++; $display("FAIL wrap_addr_seq: got %h %h want fff 000", log_addr[3], log_addr[4]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_empty_load();
      int we0 = we_cnt;
      start_load(32'h0000_0040, 11'd0);
      n_cmp += 4;
      if (done !== 1'b1)     begin n_mis++; $display("FAIL empty_done: got %b want 1", done); end
      if (busy !== 1'b0)     begin n_mis++; $display("FAIL empty_busy: got %b want 0", busy); end
      if (in_ready !== 1'b0) begin n_mis++; $display("FAIL empty_ready: got %b want 0", in_ready); end
      if (cpu_hold !== 1'b1) begin n_mis++; $display("FAIL empty_hold_during_done: got %b want 1", cpu_hold); end
      @(negedge clk);
      n_cmp += 3;
      if (done !== 1'b0)      begin n_mis++; $display("FAIL empty_done_width: got %b want 0", done); end
      if (cpu_hold !== 1'b0)  begin n_mis++; $display("FAIL empty_release: got %b want 0", cpu_hold); end
      if (we_cnt !== we0)     begin n_mis++; $display("FAIL empty_no_we: got %0d writes want 0", we_cnt - we0); end
   endtask

   task automatic test_back_to_back_gapped();
      logic [31:0] words [3];
      int w; int gap;
      int we0 = we_cnt; int d0 = done_cnt; int v0 = viol_cnt;
      words[0] = 32'h0102_0304; words[1] = 32'hA5A5_5A5A; words[2] = 32'hFEDC_BA98;
      start_load(32'h0000_0200, 11'd3);
      for (int i = 0; i < 3; i++) begin
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            start = 1'b1; base_addr = 32'h0000_0800; word_count = 11'd5;
            @(negedge clk);
         end
         start = 1'b0;
         send_word(words[i]);
         // junk handshake and start while the word is being written
         in_valid = 1'b1; in_data = 32'hBAAD_F00D;
         start = 1'b1; base_addr = 32'h0000_0800; word_count = 11'd5;
         repeat (3) @(negedge clk);
         in_valid = 1'b0; in_data = 32'h0; start = 1'b0;
      end
      wait_done(20, w);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({mem[12'h203 + 12'(4*i)], mem[12'h202 + 12'(4*i)], mem[12'h201 + 12'(4*i)],
              mem[12'h200 + 12'(4*i)]} !== words[i]) begin
            n_mis++; $display("FAIL gap_word%0d: got %h%h%h%h want %h", i,
                              mem[12'h203 + 12'(4*i)], mem[12'h202 + 12'(4*i)],
                              mem[12'h201 + 12'(4*i)], mem[12'h200 + 12'(4*i)], words[i]);
         end
      end
      @(negedge clk);
      n_cmp += 5;
      if (we_cnt - we0 !== 12)  begin n_mis++; $display("FAIL gap_nwrites: got %0d want 12", we_cnt - we0); end
      if (done_cnt - d0 !== 1)  begin n_mis++; $display("FAIL gap_done_count: got %0d want 1", done_cnt - d0); end
      if (viol_cnt !== v0)      begin n_mis++; $display("FAIL gap_ready_in_write: got %0d cycles want 0", viol_cnt - v0); end
      if (mem[12'h800] !== 8'h00) begin n_mis++; $display("FAIL gap_start_ignored: got %h want 00", mem[12'h800]); end
      if (cpu_hold !== 1'b0)    begin n_mis++; $display("FAIL gap_release: got %b want 0", cpu_hold); end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      rst_n = 1'b0; start = 1'b0; base_addr = 32'h0; word_count = 11'd0;
      in_valid = 1'b0; in_data = 32'h0;
      @(negedge clk);
      test_reset();
      test_reset_mid_load();
      test_single_word();
      test_misaligned();
      test_wrap();
      test_empty_load();
      test_back_to_back_gapped();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
